// File: rtl/level_score_tracker.sv
// level_score_tracker
//   Game-progress bookkeeping. Accepts line-clear reports and keeps a BCD
//   score, a saturating binary line total and the current level. A report's
//   base points are added (level+1) times, one BCD add per cycle. The line
//   and level bookkeeping then happens in a single update cycle.
//
// Ports
//   clk             system clock
//   srst            synchronous active-high reset
//   game_start_i    one-cycle pulse, clears everything like srst
//   lines_valid_i   line-clear report strobe
//   lines_cnt_i     lines cleared in this report (1..4 accepted)
//   busy_o          accumulation in progress, reports dropped while high
//   score_o         BCD score, digit 0 in [3:0]
//   lines_total_o   binary total lines, saturates at 65535
//   level_o         current level, 0..MAX_LEVEL
//   level_changed_o one-cycle pulse when the level increments
module level_score_tracker #(
    parameter int unsigned LINES_PER_LEVEL = 10,
    parameter int unsigned MAX_LEVEL       = 15,
    parameter int unsigned SCORE_DIGITS    = 6
) (
    input  logic                      clk,
    input  logic                      srst,
    input  logic                      game_start_i,
    input  logic                      lines_valid_i,
    input  logic [2:0]                lines_cnt_i,
    output logic                      busy_o,
    output logic [4*SCORE_DIGITS-1:0] score_o,
    output logic [15:0]               lines_total_o,
    output logic [4:0]                level_o,
    output logic                      level_changed_o
);

    localparam int unsigned SW = 4 * SCORE_DIGITS;

    typedef enum logic [1:0] {IDLE, ADD, UPDATE} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] score_q, score_d;
    logic [SW-1:0] base_q, base_d;
    logic [15:0]   lines_total_q, lines_total_d;
    logic [4:0]    level_q, level_d;
    logic [7:0]    lil_q, lil_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [5:0]    reps_q, reps_d;
    logic          pulse_q, pulse_d;

    logic [SW-1:0] bcd_sum;
    logic          bcd_carry;
    logic [4:0]    dsum;
    logic [16:0]   lt_sum;
    logic [8:0]    lil_sum;

    // Ripple BCD add of the base points; a carry out of the top digit
    // saturates to all 9s, and an all-9s score then keeps carrying out,
    // so saturation is sticky without a separate flag.
    always_comb begin
        bcd_sum   = '0;
        bcd_carry = 1'b0;
        dsum      = '0;
        for (int unsigned i = 0; i < SCORE_DIGITS; i++) begin
            dsum = {1'b0, score_q[4*i +: 4]} + {1'b0, base_q[4*i +: 4]}
                 + {4'b0, bcd_carry};
            if (dsum > 5'd9) begin
                dsum      = dsum + 5'd6;
                bcd_carry = 1'b1;
            end else begin
                bcd_carry = 1'b0;
            end
            bcd_sum[4*i +: 4] = dsum[3:0];
        end
        if (bcd_carry) begin
            bcd_sum = {SCORE_DIGITS{4'h9}};
        end
    end

    assign lt_sum  = {1'b0, lines_total_q} + {14'b0, cnt_q};
    assign lil_sum = {1'b0, lil_q} + {6'b0, cnt_q};

    always_comb begin
        state_d       = state_q;
        score_d       = score_q;
        base_d        = base_q;
        lines_total_d = lines_total_q;
        level_d       = level_q;
        lil_d         = lil_q;
        cnt_d         = cnt_q;
        reps_d        = reps_q;
        pulse_d       = 1'b0;

        if (srst || game_start_i) begin
            state_d       = IDLE;
            score_d       = '0;
            base_d        = '0;
            lines_total_d = '0;
            level_d       = '0;
            lil_d         = '0;
            cnt_d         = '0;
            reps_d        = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (lines_valid_i && (lines_cnt_i >= 3'd1) && (lines_cnt_i <= 3'd4)) begin
                        cnt_d  = lines_cnt_i;
                        reps_d = {1'b0, level_q} + 6'd1;
                        case (lines_cnt_i)
                            3'd1:    base_d = SW'(16'h0040);
                            3'd2:    base_d = SW'(16'h0100);
                            3'd3:    base_d = SW'(16'h0300);
                            default: base_d = SW'(16'h1200);
                        endcase
                        state_d = ADD;
                    end
                end
                ADD: begin
                    score_d = bcd_sum;
                    if (reps_q == 6'd1) begin
                        state_d = UPDATE;
                    end else begin
                        reps_d = reps_q - 6'd1;
                    end
                end
                UPDATE: begin
                    lines_total_d = lt_sum[16] ? 16'hFFFF : lt_sum[15:0];
                    if (lil_sum >= 9'(LINES_PER_LEVEL)) begin
                        lil_d = 8'(lil_sum - 9'(LINES_PER_LEVEL));
                        if (level_q < 5'(MAX_LEVEL)) begin
                            level_d = level_q + 5'd1;
                            pulse_d = 1'b1;
                        end
                    end else begin
                        lil_d = lil_sum[7:0];
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state_q       <= state_d;
        score_q       <= score_d;
        base_q        <= base_d;
        lines_total_q <= lines_total_d;
        level_q       <= level_d;
        lil_q         <= lil_d;
        cnt_q         <= cnt_d;
        reps_q        <= reps_d;
        pulse_q       <= pulse_d;
    end

    assign busy_o          = (state_q != IDLE);
    assign score_o         = score_q;
    assign lines_total_o   = lines_total_q;
    assign level_o         = level_q;
    assign level_changed_o = pulse_q;

endmodule

// File: tb/tb_level_score_tracker.sv
// Scoreboard bench for level_score_tracker: three parameter builds share a
// clock and reset; the driver pushes the expected completion for each report
// and a monitor compares whenever the selected DUT's busy_o falls.
module tb_level_score_tracker;

    logic       clk = 1'b0;
    logic       srst;
    logic       gs [3];
    logic       lv [3];
    logic [2:0] lc [3];

    logic        busy0, busy1, busy2;
    logic [23:0] score0, score1;
    logic [15:0] score2;
    logic [15:0] lt0, lt1, lt2;
    logic [4:0]  lvl0, lvl1, lvl2;
    logic        pl0, pl1, pl2;

    int checks   = 0;
    int failures = 0;
    int sel      = 0;

    typedef struct {
        logic [23:0] score;
        logic [15:0] lines;
        logic [4:0]  level;
        logic        pulse;
        int          busy_cycles;
    } exp_t;

    exp_t expq[$];

    always #5 clk = ~clk;

    level_score_tracker u_dut0 (
        .clk(clk), .srst(srst), .game_start_i(gs[0]), .lines_valid_i(lv[0]),
        .lines_cnt_i(lc[0]), .busy_o(busy0), .score_o(score0),
        .lines_total_o(lt0), .level_o(lvl0), .level_changed_o(pl0)
    );

    level_score_tracker #(.MAX_LEVEL(2), .LINES_PER_LEVEL(5)) u_dut1 (
        .clk(clk), .srst(srst), .game_start_i(gs[1]), .lines_valid_i(lv[1]),
        .lines_cnt_i(lc[1]), .busy_o(busy1), .score_o(score1),
        .lines_total_o(lt1), .level_o(lvl1), .level_changed_o(pl1)
    );

    level_score_tracker #(.SCORE_DIGITS(4), .LINES_PER_LEVEL(255)) u_dut2 (
        .clk(clk), .srst(srst), .game_start_i(gs[2]), .lines_valid_i(lv[2]),
        .lines_cnt_i(lc[2]), .busy_o(busy2), .score_o(score2),
        .lines_total_o(lt2), .level_o(lvl2), .level_changed_o(pl2)
    );

    logic        busy_m, pulse_m;
    logic [23:0] score_m;
    logic [15:0] lines_m;
    logic [4:0]  level_m;

    always_comb begin
        busy_m = busy0; pulse_m = pl0; score_m = score0; lines_m = lt0; level_m = lvl0;
        case (sel)
            1: begin busy_m = busy1; pulse_m = pl1; score_m = score1; lines_m = lt1; level_m = lvl1; end
            2: begin busy_m = busy2; pulse_m = pl2; score_m = {8'h00, score2}; lines_m = lt2; level_m = lvl2; end
            default: ;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a busy_o falling edge marks a finished report.
    logic prev_busy = 1'b0;
    int   bc = 0;
    exp_t e;
    always @(negedge clk) begin
        if (prev_busy && !busy_m) begin
            if (expq.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_completion on dut%0d", sel);
            end else begin
                e = expq.pop_front();
                chk("score",     32'(score_m), 32'(e.score));
                chk("lines",     32'(lines_m), 32'(e.lines));
                chk("level",     32'(level_m), 32'(e.level));
                chk("pulse",     32'(pulse_m), 32'(e.pulse));
                chk("busy_len",  32'(bc),      32'(e.busy_cycles));
            end
        end else if (pulse_m) begin
            checks++; failures++;
            $display("FAIL stray_pulse on dut%0d: got 1 expected 0", sel);
        end
        if (busy_m) bc = prev_busy ? bc + 1 : 1;
        prev_busy = busy_m;
    end

    task automatic wait_done();
        int n = 0;
        while (expq.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (expq.size() != 0) begin
            checks++; failures++;
            $display("FAIL completion_timeout on dut%0d: got busy pending expected done", sel);
            expq.delete();
        end
        @(negedge clk);
    endtask

    task automatic send(input int d, input logic [2:0] cnt, input logic [23:0] sc,
                        input logic [15:0] ln, input logic [4:0] lvl, input logic pl,
                        input int blen, input bit inject = 1'b0);
        exp_t x;
        x.score = sc; x.lines = ln; x.level = lvl; x.pulse = pl; x.busy_cycles = blen;
        sel = d;
        expq.push_back(x);
        @(negedge clk); lv[d] = 1'b1; lc[d] = cnt;
        @(negedge clk); lv[d] = 1'b0;
        if (inject) begin
            // Second report while busy must be dropped.
            lv[d] = 1'b1; lc[d] = 3'd4;
            @(negedge clk); lv[d] = 1'b0;
        end
        wait_done();
    endtask

    task automatic pulse_start(input int d);
        @(negedge clk); gs[d] = 1'b1;
        @(negedge clk); gs[d] = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin gs[i] = 1'b0; lv[i] = 1'b0; lc[i] = 3'd0; end
        srst = 1'b1;
        repeat (3) @(negedge clk);
        srst = 1'b0;
        @(negedge clk);
        chk("rst_score",  32'(score0), 32'h0);
        chk("rst_lines",  32'(lt0),    32'h0);
        chk("rst_level",  32'(lvl0),   32'h0);
        chk("rst_busy",   32'(busy0),  32'h0);
        chk("rst_pulse",  32'(pl0),    32'h0);
        chk("rst_score4", 32'(score2), 32'h0);

        // Default build.
        send(0, 3'd1, 24'h000040, 16'd1, 5'd0, 1'b0, 2);
        pulse_start(0);
        send(0, 3'd4, 24'h001200, 16'd4,  5'd0, 1'b0, 2);
        send(0, 3'd4, 24'h002400, 16'd8,  5'd0, 1'b0, 2);
        send(0, 3'd2, 24'h002500, 16'd10, 5'd1, 1'b1, 2);
        send(0, 3'd1, 24'h002580, 16'd11, 5'd1, 1'b0, 3);
        send(0, 3'd2, 24'h002780, 16'd13, 5'd1, 1'b0, 3, 1'b1);

        // Abort mid-ADD: busy lasts one cycle, everything reads zero after.
        begin
            exp_t x;
            x.score = '0; x.lines = '0; x.level = '0; x.pulse = 1'b0; x.busy_cycles = 1;
            expq.push_back(x);
            @(negedge clk); lv[0] = 1'b1; lc[0] = 3'd3;
            @(negedge clk); lv[0] = 1'b0; gs[0] = 1'b1;
            @(negedge clk); gs[0] = 1'b0;
            wait_done();
        end

        // Illegal counts are ignored.
        for (int k = 0; k < 3; k++) begin
            logic [2:0] bad [3];
            bad[0] = 3'd0; bad[1] = 3'd5; bad[2] = 3'd7;
            @(negedge clk); lv[0] = 1'b1; lc[0] = bad[k];
            @(negedge clk); lv[0] = 1'b0;
            chk("bad_cnt_busy", 32'(busy0), 32'h0);
            @(negedge clk);
            chk("bad_cnt_busy2", 32'(busy0), 32'h0);
        end
        send(0, 3'd2, 24'h000100, 16'd2, 5'd0, 1'b0, 2);

        // MAX_LEVEL=2, LINES_PER_LEVEL=5.
        send(1, 3'd3, 24'h000300, 16'd3,  5'd0, 1'b0, 2);
        send(1, 3'd3, 24'h000600, 16'd6,  5'd1, 1'b1, 2);
        send(1, 3'd3, 24'h001200, 16'd9,  5'd1, 1'b0, 3);
        send(1, 3'd3, 24'h001800, 16'd12, 5'd2, 1'b1, 3);
        send(1, 3'd3, 24'h002700, 16'd15, 5'd2, 1'b0, 4);
        send(1, 3'd3, 24'h003600, 16'd18, 5'd2, 1'b0, 4);
        send(1, 3'd3, 24'h004500, 16'd21, 5'd2, 1'b0, 4);
        send(1, 3'd3, 24'h005400, 16'd24, 5'd2, 1'b0, 4);
        send(1, 3'd3, 24'h006300, 16'd27, 5'd2, 1'b0, 4);
        send(1, 3'd3, 24'h007200, 16'd30, 5'd2, 1'b0, 4);

        // SCORE_DIGITS=4: saturation at 9999 and stays there.
        send(2, 3'd4, 24'h001200, 16'd4,  5'd0, 1'b0, 2);
        send(2, 3'd4, 24'h002400, 16'd8,  5'd0, 1'b0, 2);
        send(2, 3'd4, 24'h003600, 16'd12, 5'd0, 1'b0, 2);
        send(2, 3'd4, 24'h004800, 16'd16, 5'd0, 1'b0, 2);
        send(2, 3'd4, 24'h006000, 16'd20, 5'd0, 1'b0, 2);
        send(2, 3'd4, 24'h007200, 16'd24, 5'd0, 1'b0, 2);
        send(2, 3'd4, 24'h008400, 16'd28, 5'd0, 1'b0, 2);
        send(2, 3'd4, 24'h009600, 16'd32, 5'd0, 1'b0, 2);
        send(2, 3'd4, 24'h009999, 16'd36, 5'd0, 1'b0, 2);
        send(2, 3'd1, 24'h009999, 16'd37, 5'd0, 1'b0, 2);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
